slave_in_port: RTL and testbench

- Slave-side receiver that sits directly downstream of the master output port on the serial bus.
- Accepts the master_valid/slave_ready handshake, then deserialises the 12-bit address and 8-bit data streams, sent LSB first on two 1-bit lines.
- Presents the captured parallel address and data, plus a one-cycle write or read strobe, to the slave memory.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/slave_in_port_if.sv | 30 +++
 rtl/sipo_shift_reg.sv | 36 +++
 rtl/slave_in_port.sv | 138 +++++++++++++
 tb/tb_slave_in_port.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: field widths, mode encoding and the
// receiver state encoding used by both ends of the handshake.
package bus_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 8;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DONE = 2'b10
  } rx_state_e;

  // Index width for a bit position within a field; never narrower than 1.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/slave_in_port_if.sv
// Serial bus between the master output port and the slave input port,
// plus the parallel side presented to the slave memory.
interface slave_in_port_if #(
  parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH
);

  logic                  master_valid;
  logic                  mode;
  logic                  rx_address;
  logic                  rx_data;
  logic                  slave_busy;
  logic                  slave_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  write_en;
  logic                  read_en;
  logic                  rx_done;

  modport master (
    output master_valid, mode, rx_address, rx_data, slave_busy,
    input  slave_ready, address, data, write_en, read_en, rx_done
  );

  modport slave (
    input  master_valid, mode, rx_address, rx_data, slave_busy,
    output slave_ready, address, data, write_en, read_en, rx_done
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out capture register: writes one bit at a given index
// when enabled and exposes the value it will hold after the next edge.
module sipo_shift_reg #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic             bit_in,
  output logic [WIDTH-1:0] shift_next
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Out-of-range indices are dropped so non power-of-two widths stay safe.
  always_comb begin
    shift_d = shift_q;
    if (en && (int'(idx) < WIDTH)) begin
      shift_d[idx] = bit_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign shift_next = shift_d;

endmodule

// File: rtl/slave_in_port.sv
// Slave-side serial receiver: handshakes with the master, deserialises the
// LSB-first address/data lines and pulses a write or read strobe for one cycle.
module slave_in_port #(
  parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  slave_in_port_if.slave  bus
);

  import bus_pkg::*;

  // DATA_WIDTH must not exceed ADDR_WIDTH: data bits ride on the address count.
  localparam int CNT_W  = idx_width(ADDR_WIDTH);
  localparam int DIDX_W = idx_width(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_en_q, write_en_d;
  logic                  read_en_q, read_en_d;
  logic                  rx_done_q, rx_done_d;

  logic                  slave_ready;
  logic                  addr_en;
  logic                  data_en;
  logic                  last_bit;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_next;

  assign slave_ready = (state_q == IDLE) && !bus.slave_busy && !reset;
  assign last_bit    = (cnt_q == CNT_W'(ADDR_WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    address_d  = address_q;
    data_d     = data_q;
    write_en_d = 1'b0;
    read_en_d  = 1'b0;
    rx_done_d  = 1'b0;
    addr_en    = 1'b0;
    data_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.master_valid && slave_ready) begin
          mode_d  = bus.mode;
          cnt_d   = '0;
          state_d = RECV;
        end
      end

      RECV: begin
        addr_en = 1'b1;
        data_en = (mode_q == MODE_WRITE) && (int'(cnt_q) < DATA_WIDTH);
        cnt_d   = cnt_q + CNT_W'(1);
        // The final bit is merged straight into the outputs on the same edge.
        if (last_bit) begin
          address_d  = addr_next;
          if (mode_q == MODE_WRITE) begin
            data_d = data_next;
          end
          rx_done_d  = 1'b1;
          write_en_d = (mode_q == MODE_WRITE);
          read_en_d  = (mode_q == MODE_READ);
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= MODE_READ;
      address_q  <= '0;
      data_q     <= '0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      address_q  <= address_d;
      data_q     <= data_d;
      write_en_q <= write_en_d;
      read_en_q  <= read_en_d;
      rx_done_q  <= rx_done_d;
    end
  end

  sipo_shift_reg #(
    .WIDTH (ADDR_WIDTH),
    .IDX_W (CNT_W)
  ) u_addr_sr (
    .clk        (clk),
    .reset      (reset),
    .en         (addr_en),
    .idx        (cnt_q),
    .bit_in     (bus.rx_address),
    .shift_next (addr_next)
  );

  sipo_shift_reg #(
    .WIDTH (DATA_WIDTH),
    .IDX_W (DIDX_W)
  ) u_data_sr (
    .clk        (clk),
    .reset      (reset),
    .en         (data_en),
    .idx        (cnt_q[DIDX_W-1:0]),
    .bit_in     (bus.rx_data),
    .shift_next (data_next)
  );

  assign bus.slave_ready = slave_ready;
  assign bus.address     = address_q;
  assign bus.data        = data_q;
  assign bus.write_en    = write_en_q;
  assign bus.read_en     = read_en_q;
  assign bus.rx_done     = rx_done_q;

endmodule

// File: tb/tb_slave_in_port.sv
// Self-checking bench for slave_in_port: directed table, busy/reset corner
// sequences and randomised transactions against a transaction-level model.
module tb_slave_in_port;

  import bus_pkg::*;

  typedef struct {
    logic        m;
    logic [11:0] a;
    logic [7:0]  d;
    bit          hold;
    logic [11:0] exp_a;
    logic [7:0]  exp_d;
    logic        exp_w;
  } vec_t;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    int          wait_cyc;
    int          stb_at;
    int          wn;
    int          rn;
    int          dn;
    int          rlow;
    int          achg;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] mdl_addr;
  logic [7:0]  mdl_data;

  slave_in_port_if bus();

  slave_in_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One full transaction: handshake, 12 serial bits, observe through DONE+1.
  task automatic applyStimulus(input logic m, input logic [11:0] a, input logic [7:0] d,
                               input bit hold, input int busy_on, output res_t r);
    logic [11:0] a0;
    r = '{a: '0, d: '0, wait_cyc: 0, stb_at: -1, wn: 0, rn: 0, dn: 0, rlow: 0, achg: 0};
    bus.master_valid = 1'b1;
    bus.mode         = m;
    while (!bus.slave_ready && r.wait_cyc < 50) begin
      stepClk();
      r.wait_cyc++;
    end
    if (!bus.slave_ready) begin
      checkOutput("handshake_timeout", 32'(bus.slave_ready), 32'd1);
      return;
    end
    stepClk();
    a0 = bus.address;
    for (int e = 0; e <= 13; e++) begin
      if (!bus.slave_ready) r.rlow++;
      if (bus.write_en) begin
        r.wn++;
        if (r.stb_at < 0) r.stb_at = e;
      end
      if (bus.read_en) begin
        r.rn++;
        if (r.stb_at < 0) r.stb_at = e;
      end
      if (bus.rx_done) r.dn++;
      if (e <= 11 && bus.address !== a0) r.achg++;
      if (e == 0 && !hold) bus.master_valid = 1'b0;
      if (e < 12) begin
        bus.rx_address = a[e];
        bus.rx_data    = (e < 8) ? d[e] : 1'($urandom);
      end else begin
        bus.rx_address = 1'($urandom);
        bus.rx_data    = 1'($urandom);
      end
      if (busy_on > 0 && e == busy_on) bus.slave_busy = 1'b1;
      if (busy_on > 0 && e == 11) bus.slave_busy = 1'b0;
      if (e < 13) stepClk();
    end
    r.a = bus.address;
    r.d = bus.data;
  endtask

  task automatic checkTxn(input string tag, input res_t r, input logic [11:0] ea,
                          input logic [7:0] ed, input logic ew);
    checkOutput({tag, "_addr"},     32'(r.a),        32'(ea));
    checkOutput({tag, "_data"},     32'(r.d),        32'(ed));
    checkOutput({tag, "_wr_cnt"},   32'(r.wn),       ew ? 32'd1 : 32'd0);
    checkOutput({tag, "_rd_cnt"},   32'(r.rn),       ew ? 32'd0 : 32'd1);
    checkOutput({tag, "_done_cnt"}, 32'(r.dn),       32'd1);
    checkOutput({tag, "_stb_at"},   32'(r.stb_at),   32'd12);
    checkOutput({tag, "_rdy_low"},  32'(r.rlow),     32'd13);
    checkOutput({tag, "_addr_chg"}, 32'(r.achg),     32'd0);
    checkOutput({tag, "_hs_wait"},  32'(r.wait_cyc), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    res_t r;
    int   cnt_a;
    int   cnt_b;
    bit   prev_hold;

    vecs[0] = '{m: 1'b1, a: 12'hA5C, d: 8'h3B, hold: 1'b0, exp_a: 12'hA5C, exp_d: 8'h3B, exp_w: 1'b1};
    vecs[1] = '{m: 1'b0, a: 12'h123, d: 8'h55, hold: 1'b0, exp_a: 12'h123, exp_d: 8'h3B, exp_w: 1'b0};
    vecs[2] = '{m: 1'b1, a: 12'h001, d: 8'hFF, hold: 1'b1, exp_a: 12'h001, exp_d: 8'hFF, exp_w: 1'b1};
    vecs[3] = '{m: 1'b1, a: 12'hFFE, d: 8'h80, hold: 1'b1, exp_a: 12'hFFE, exp_d: 8'h80, exp_w: 1'b1};

    reset            = 1'b1;
    bus.master_valid = 1'b0;
    bus.mode         = 1'b0;
    bus.rx_address   = 1'b0;
    bus.rx_data      = 1'b0;
    bus.slave_busy   = 1'b0;

    stepClk();
    stepClk();
    checkOutput("rst_ready",    32'(bus.slave_ready), 32'd0);
    checkOutput("rst_address",  32'(bus.address),     32'd0);
    checkOutput("rst_data",     32'(bus.data),        32'd0);
    checkOutput("rst_write_en", 32'(bus.write_en),    32'd0);
    checkOutput("rst_read_en",  32'(bus.read_en),     32'd0);
    checkOutput("rst_rx_done",  32'(bus.rx_done),     32'd0);

    reset = 1'b0;
    #1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.slave_ready) cnt_a++;
      if (bus.write_en || bus.read_en || bus.rx_done) cnt_b++;
      stepClk();
    end
    checkOutput("idle_ready_low", 32'(cnt_a), 32'd0);
    checkOutput("idle_strobes",   32'(cnt_b), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].m, vecs[i].a, vecs[i].d, vecs[i].hold, 0, r);
      checkTxn($sformatf("vec%0d", i), r, vecs[i].exp_a, vecs[i].exp_d, vecs[i].exp_w);
    end
    bus.master_valid = 1'b0;
    stepClk();

    $display("[TB] busy gating sequence");
    bus.mode         = 1'b1;
    bus.master_valid = 1'b1;
    bus.slave_busy   = 1'b1;
    #1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.slave_ready) cnt_a++;
      if (bus.write_en || bus.read_en || bus.rx_done) cnt_b++;
      stepClk();
    end
    checkOutput("busy_ready_high", 32'(cnt_a), 32'd0);
    checkOutput("busy_strobes",    32'(cnt_b), 32'd0);
    bus.slave_busy = 1'b0;
    #1;
    checkOutput("busy_release_ready", 32'(bus.slave_ready), 32'd1);
    applyStimulus(1'b1, 12'h3C3, 8'h96, 1'b0, 4, r);
    checkTxn("busy_txn", r, 12'h3C3, 8'h96, 1'b1);

    $display("[TB] reset during receive");
    bus.master_valid = 1'b1;
    bus.mode         = 1'b1;
    stepClk();
    bus.master_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.rx_address = 1'b1;
      bus.rx_data    = 1'b1;
      stepClk();
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst_address", 32'(bus.address),     32'd0);
    checkOutput("midrst_data",    32'(bus.data),        32'd0);
    checkOutput("midrst_ready",   32'(bus.slave_ready), 32'd0);
    stepClk();
    reset = 1'b0;
    cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.write_en || bus.read_en || bus.rx_done) cnt_b++;
      stepClk();
    end
    checkOutput("midrst_strobes",    32'(cnt_b),       32'd0);
    checkOutput("midrst_addr_after", 32'(bus.address), 32'd0);
    checkOutput("midrst_data_after", 32'(bus.data),    32'd0);
    applyStimulus(1'b1, 12'h0F0, 8'h55, 1'b0, 0, r);
    checkTxn("post_rst", r, 12'h0F0, 8'h55, 1'b1);
    mdl_addr = 12'h0F0;
    mdl_data = 8'h55;

    $display("[TB] randomised transactions");
    prev_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic        m;
      logic [11:0] a;
      logic [7:0]  d;
      bit          hold;
      int          gap;
      int          busy_on;
      m       = 1'($urandom);
      a       = 12'($urandom);
      d       = 8'($urandom);
      hold    = 1'($urandom);
      gap     = prev_hold ? 0 : int'($urandom_range(0, 3));
      busy_on = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0;
      if (gap > 0) begin
        bus.master_valid = 1'b0;
        for (int g = 0; g < gap; g++) stepClk();
      end
      applyStimulus(m, a, d, hold, busy_on, r);
      mdl_addr = a;
      if (m == MODE_WRITE) mdl_data = d;
      checkTxn($sformatf("rnd%0d", i), r, mdl_addr, mdl_data, m);
      prev_hold = hold;
    end
    bus.master_valid = 1'b0;
    stepClk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
